// File: rtl/multi_channel_timer.sv
// Memory-mapped free-running timer with CHANNELS one-shot/periodic compare channels and W1C pending bits.
// Optional prescaler: define MTIMER_PRESCALER_EN to build the PRESCALER register and divide counter.
module multi_channel_timer #(
    parameter int CHANNELS        = 4,
    parameter int TIMER_WIDTH     = 64,
    parameter int PRESCALER_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                write_i,
    input  logic [5:0]          write_address_i,
    input  logic [31:0]         write_data_i,
    input  logic [5:0]          read_address_i,
    output logic [31:0]         read_data_o,
    output logic [CHANNELS-1:0] channel_irq_o,
    output logic                timer_interrupt_o
);
    localparam int HW = TIMER_WIDTH - 32;

    logic [TIMER_WIDTH-1:0] timer_r;
    logic                   enable_r;
    logic [CHANNELS-1:0]    pending_r;
    logic [CHANNELS-1:0]    ie_r;
    logic [CHANNELS-1:0]    periodic_r;
    logic [CHANNELS-1:0]    match_q_r;
    logic [TIMER_WIDTH-1:0] compare_r [CHANNELS];
    logic [31:0]            period_r  [CHANNELS];

    logic                   wr_timer_lo_s;
    logic                   wr_timer_hi_s;
    logic                   wr_control_s;
    logic                   wr_status_s;
    logic [CHANNELS-1:0]    wr_ch_s;
    logic [CHANNELS-1:0]    match_s;
    logic [CHANNELS-1:0]    event_s;
    logic                   tick_s;
    logic [31:0]            field_s;
    logic [31:0]            chan_rd_s;
    logic [31:0]            read_data_s;

    // Write strobe decode; each channel owns a 4-word block starting at word 8
    always_comb begin
        wr_timer_lo_s = write_i && (write_address_i == 6'd0);
        wr_timer_hi_s = write_i && (write_address_i == 6'd1);
        wr_control_s  = write_i && (write_address_i == 6'd2);
        wr_status_s   = write_i && (write_address_i == 6'd3);
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ch_s[c] = write_i && (write_address_i[5:2] == 4'(c + 2));
        end
    end

    // Unsigned match against compare and rising-edge event detection
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            match_s[c] = (timer_r >= compare_r[c]);
        end
        event_s = match_s & ~match_q_r;
    end

`ifdef MTIMER_PRESCALER_EN
    logic [PRESCALER_WIDTH-1:0] prescaler_r;
    logic [PRESCALER_WIDTH-1:0] prescale_cnt_r;
    logic                       wr_prescaler_s;

    assign wr_prescaler_s = write_i && (write_address_i == 6'd4);
    assign tick_s         = enable_r && (prescale_cnt_r >= prescaler_r);

    // Prescaler register and divide counter; a PRESCALER write restarts the count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prescaler_r    <= {PRESCALER_WIDTH{1'b0}};
            prescale_cnt_r <= {PRESCALER_WIDTH{1'b0}};
        end else if (wr_prescaler_s) begin
            prescaler_r    <= write_data_i[PRESCALER_WIDTH-1:0];
            prescale_cnt_r <= {PRESCALER_WIDTH{1'b0}};
        end else if (tick_s) begin
            prescale_cnt_r <= {PRESCALER_WIDTH{1'b0}};
        end else if (enable_r) begin
            prescale_cnt_r <= prescale_cnt_r + PRESCALER_WIDTH'(1'b1);
        end
    end
`else
    assign tick_s = enable_r;
`endif

    // Free-running counter; a half-word write takes priority over the increment
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            timer_r <= {TIMER_WIDTH{1'b0}};
        end else if (wr_timer_lo_s) begin
            timer_r[31:0] <= write_data_i;
        end else if (wr_timer_hi_s) begin
            timer_r[TIMER_WIDTH-1:32] <= write_data_i[HW-1:0];
        end else if (tick_s) begin
            timer_r <= timer_r + TIMER_WIDTH'(1'b1);
        end
    end

    // CONTROL enable and sticky pending bits; a new event wins over a W1C clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enable_r  <= 1'b1;
            pending_r <= {CHANNELS{1'b0}};
        end else begin
            if (wr_control_s) begin
                enable_r <= write_data_i[0];
            end
            if (wr_status_s) begin
                pending_r <= (pending_r & ~write_data_i[CHANNELS-1:0]) | event_s;
            end else begin
                pending_r <= pending_r | event_s;
            end
        end
    end

    // Per-channel configuration, periodic compare reload and match history
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                compare_r[c] <= {TIMER_WIDTH{1'b1}};
                period_r[c]  <= 32'h0;
            end
            ie_r       <= {CHANNELS{1'b0}};
            periodic_r <= {CHANNELS{1'b0}};
            match_q_r  <= {CHANNELS{1'b1}};
        end else begin
            match_q_r <= match_s;
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_ch_s[c] && (write_address_i[1:0] == 2'd0)) begin
                    compare_r[c][31:0] <= write_data_i;
                end else if (wr_ch_s[c] && (write_address_i[1:0] == 2'd1)) begin
                    compare_r[c][TIMER_WIDTH-1:32] <= write_data_i[HW-1:0];
                end else if (event_s[c] && periodic_r[c]) begin
                    compare_r[c] <= compare_r[c] + TIMER_WIDTH'(period_r[c]);
                end
                if (wr_ch_s[c] && (write_address_i[1:0] == 2'd2)) begin
                    period_r[c] <= write_data_i;
                end
                if (wr_ch_s[c] && (write_address_i[1:0] == 2'd3)) begin
                    ie_r[c]       <= write_data_i[0];
                    periodic_r[c] <= write_data_i[1];
                end
            end
        end
    end

    // Channel register read-back; at most one channel block is selected
    always_comb begin
        chan_rd_s = 32'h0;
        field_s   = 32'h0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (read_address_i[1:0])
                2'd0:    field_s = compare_r[c][31:0];
                2'd1:    field_s = 32'(compare_r[c][TIMER_WIDTH-1:32]);
                2'd2:    field_s = period_r[c];
                default: field_s = {30'h0, periodic_r[c], ie_r[c]};
            endcase
            chan_rd_s = chan_rd_s | ({32{read_address_i[5:2] == 4'(c + 2)}} & field_s);
        end
    end

    // Register map read multiplexer
    always_comb begin
        case (read_address_i)
            6'd0:    read_data_s = timer_r[31:0];
            6'd1:    read_data_s = 32'(timer_r[TIMER_WIDTH-1:32]);
            6'd2:    read_data_s = {31'h0, enable_r};
            6'd3:    read_data_s = 32'(pending_r);
`ifdef MTIMER_PRESCALER_EN
            6'd4:    read_data_s = 32'(prescaler_r);
`else
            6'd4:    read_data_s = 32'h0;
`endif
            default: read_data_s = chan_rd_s;
        endcase
    end

    assign read_data_o       = read_data_s;
    assign channel_irq_o     = pending_r & ie_r;
    assign timer_interrupt_o = |(pending_r & ie_r);

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: vector table, directed corner sequences, random vs reference model.
module tb_multi_channel_timer;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        write_i;
    logic [5:0]  write_address_i;
    logic [31:0] write_data_i;
    logic [5:0]  read_address_i;
    logic [31:0] read_data_o;
    logic [3:0]  channel_irq_o;
    logic        timer_interrupt_o;

    always #5 clk_i = ~clk_i;

    multi_channel_timer #(.CHANNELS(4), .TIMER_WIDTH(64), .PRESCALER_WIDTH(16)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .write_i           (write_i),
        .write_address_i   (write_address_i),
        .write_data_i      (write_data_i),
        .read_address_i    (read_address_i),
        .read_data_o       (read_data_o),
        .channel_irq_o     (channel_irq_o),
        .timer_interrupt_o (timer_interrupt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept as plain register-map values
    logic [63:0] m_timer;
    bit          m_en;
    logic [3:0]  m_pend, m_ie, m_periodic, m_mq;
    logic [63:0] m_cmp [4];
    logic [31:0] m_per [4];
`ifdef MTIMER_PRESCALER_EN
    int unsigned m_psc, m_wait;
`endif

    typedef struct {
        bit          w;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [5:0]  ra;
        logic [31:0] exp_rd;
        logic [3:0]  exp_irq;
    } vec_t;
    vec_t vecs [22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_timer = 64'h0; m_en = 1'b1; m_pend = 4'h0; m_ie = 4'h0; m_periodic = 4'h0; m_mq = 4'hF;
        for (int c = 0; c < 4; c++) begin
            m_cmp[c] = 64'hFFFF_FFFF_FFFF_FFFF;
            m_per[c] = 32'h0;
        end
`ifdef MTIMER_PRESCALER_EN
        m_psc = 0; m_wait = 0;
`endif
    endtask

    // One clock of the register-map rules: events come from the state before the edge
    task automatic model_edge(input bit w, input logic [5:0] wa, input logic [31:0] wd);
        logic [3:0] hit, ev, clr;
        bit tick;
        int wc, f;
        for (int c = 0; c < 4; c++) hit[c] = (m_timer >= m_cmp[c]);
        ev = hit & ~m_mq;
        wc = -1; f = 0;
        if (w && wa >= 6'd8 && wa < 6'd24) begin
            wc = (int'(wa) - 8) / 4;
            f  = int'(wa) % 4;
        end
`ifdef MTIMER_PRESCALER_EN
        tick = m_en && (m_wait == m_psc);
        if (w && wa == 6'd4) begin m_psc = int'(wd[15:0]); m_wait = 0; end
        else if (tick) m_wait = 0;
        else if (m_en) m_wait++;
`else
        tick = m_en;
`endif
        if (w && wa == 6'd0) m_timer[31:0] = wd;
        else if (w && wa == 6'd1) m_timer[63:32] = wd;
        else if (tick) m_timer = m_timer + 64'd1;
        if (w && wa == 6'd2) m_en = wd[0];
        clr = (w && wa == 6'd3) ? wd[3:0] : 4'h0;
        m_pend = (m_pend & ~clr) | ev;
        for (int c = 0; c < 4; c++) begin
            if (wc == c && f == 0) m_cmp[c][31:0] = wd;
            else if (wc == c && f == 1) m_cmp[c][63:32] = wd;
            else if (ev[c] && m_periodic[c]) m_cmp[c] = m_cmp[c] + {32'h0, m_per[c]};
        end
        if (wc >= 0 && f == 2) m_per[wc] = wd;
        if (wc >= 0 && f == 3) begin m_ie[wc] = wd[0]; m_periodic[wc] = wd[1]; end
        m_mq = hit;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] ra);
        int c, f;
        c = (int'(ra) - 8) / 4;
        f = int'(ra) % 4;
        if (ra == 6'd0) return m_timer[31:0];
        if (ra == 6'd1) return m_timer[63:32];
        if (ra == 6'd2) return {31'h0, m_en};
        if (ra == 6'd3) return {28'h0, m_pend};
`ifdef MTIMER_PRESCALER_EN
        if (ra == 6'd4) return m_psc;
`endif
        if (ra < 6'd8 || ra >= 6'd24) return 32'h0;
        if (f == 0) return m_cmp[c][31:0];
        if (f == 1) return m_cmp[c][63:32];
        if (f == 2) return m_per[c];
        return {30'h0, m_periodic[c], m_ie[c]};
    endfunction

    // Drive one cycle, advance the model at the edge and compare #1 later
    task automatic step(input bit w, input logic [5:0] wa, input logic [31:0] wd, input logic [5:0] ra);
        write_i = w; write_address_i = wa; write_data_i = wd; read_address_i = ra;
        @(posedge clk_i);
        model_edge(w, wa, wd);
        #1;
        write_i = 1'b0;
        check("model read_data", read_data_o, model_read(ra));
        check("model channel_irq", channel_irq_o, m_pend & m_ie);
        check("model timer_interrupt", timer_interrupt_o, |(m_pend & m_ie));
    endtask

    task automatic rand_step();
        int unsigned sel, ch;
        logic [5:0]  ra, wa;
        logic [31:0] wd;
        bit          w;
        sel = $urandom_range(0, 15);
        ch  = $urandom_range(0, 3);
        ra  = 6'($urandom_range(0, 63));
        w = 1'b1; wa = 6'd0; wd = 32'h0;
        case (sel)
            6:  begin wa = 6'd3; wd = 32'($urandom_range(0, 15)); end
            7:  begin wa = 6'(8 + 4 * ch); wd = m_timer[31:0] + 32'($urandom_range(0, 24)); end
            8:  begin wa = 6'(9 + 4 * ch); wd = m_timer[63:32]; end
            9:  begin wa = 6'(10 + 4 * ch); wd = 32'($urandom_range(0, 8)); end
            10: begin wa = 6'(11 + 4 * ch); wd = 32'($urandom_range(0, 3)); end
            11: begin wa = 6'd2; wd = ($urandom_range(0, 7) != 0) ? 32'h1 : 32'h0; end
            12: begin wa = 6'd4; wd = 32'($urandom_range(0, 2)); end
            13: begin
                wa = 6'($urandom_range(0, 63));
                wd = $urandom();
                if (wa == 6'd1 || (wa >= 6'd8 && wa[1:0] == 2'd1)) wd = m_timer[63:32];
                else if (wa == 6'd4) wd = wd & 32'h3;
            end
            14: begin
                wa = 6'd0;
                wd = ($urandom_range(0, 3) == 0) ? $urandom() : m_timer[31:0] - 32'($urandom_range(0, 16));
            end
            default: w = 1'b0;
        endcase
        step(w, wa, wd, ra);
    endtask

    initial begin
        int found, cyc;
        int exp_ev [3];
        int exp_cmp [3];
        exp_ev  = '{5, 9, 13};
        exp_cmp = '{9, 13, 17};

        // {write, waddr, wdata, raddr, expected read, expected irq}
        vecs[0]  = '{1'b1, 6'd2,  32'h0,         6'd2,  32'h0,  4'h0};
        vecs[1]  = '{1'b1, 6'd0,  32'h0,         6'd0,  32'h0,  4'h0};
        vecs[2]  = '{1'b1, 6'd1,  32'h0,         6'd1,  32'h0,  4'h0};
        vecs[3]  = '{1'b1, 6'd8,  32'd10,        6'd8,  32'd10, 4'h0};
        vecs[4]  = '{1'b1, 6'd9,  32'h0,         6'd9,  32'h0,  4'h0};
        vecs[5]  = '{1'b1, 6'd11, 32'h1,         6'd11, 32'h1,  4'h0};
        vecs[6]  = '{1'b1, 6'd5,  32'hDEAD_BEEF, 6'd5,  32'h0,  4'h0};
        vecs[7]  = '{1'b1, 6'd24, 32'h1234_5678, 6'd24, 32'h0,  4'h0};
        vecs[8]  = '{1'b1, 6'd2,  32'h1,         6'd0,  32'h0,  4'h0};
        for (int k = 1; k <= 10; k++) vecs[8 + k] = '{1'b0, 6'd0, 32'h0, 6'd0, 32'(k), 4'h0};
        vecs[19] = '{1'b0, 6'd0,  32'h0,         6'd3,  32'h1,  4'h1};
        vecs[20] = '{1'b0, 6'd0,  32'h0,         6'd0,  32'd12, 4'h1};
        vecs[21] = '{1'b0, 6'd0,  32'h0,         6'd10, 32'h0,  4'h1};

        rst_n_i = 1'b0; write_i = 1'b0; write_address_i = 6'd0; write_data_i = 32'h0; read_address_i = 6'd0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1 check("reset TIMER_LO", read_data_o, 32'h0);
        check("reset channel_irq", channel_irq_o, 4'h0);
        check("reset timer_interrupt", timer_interrupt_o, 1'b0);
        read_address_i = 6'd2;
        #1 check("reset CONTROL", read_data_o, 32'h1);
        read_address_i = 6'd8;
        #1 check("reset COMPARE_LO0", read_data_o, 32'hFFFF_FFFF);
        read_address_i = 6'd3;
        #1 check("reset STATUS", read_data_o, 32'h0);
        @(negedge clk_i) rst_n_i = 1'b1;

        // Table: one-shot match on ch0 at timer 10, pending one cycle later, counter keeps running
        foreach (vecs[i]) begin
            step(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].ra);
            check($sformatf("vec%0d read_data", i), read_data_o, vecs[i].exp_rd);
            check($sformatf("vec%0d channel_irq", i), channel_irq_o, vecs[i].exp_irq);
            check($sformatf("vec%0d timer_interrupt", i), timer_interrupt_o, |vecs[i].exp_irq);
        end

        // Periodic ch1: compare 5, period 4, cleared after each event
        step(1'b1, 6'd2, 32'h0, 6'd0);
        step(1'b1, 6'd11, 32'h0, 6'd11);
        step(1'b1, 6'd8, 32'hFFFF_FFFF, 6'd8);
        step(1'b1, 6'd9, 32'hFFFF_FFFF, 6'd9);
        step(1'b1, 6'd0, 32'h0, 6'd0);
        step(1'b1, 6'd12, 32'd5, 6'd12);
        step(1'b1, 6'd13, 32'h0, 6'd13);
        step(1'b1, 6'd14, 32'd4, 6'd14);
        step(1'b1, 6'd15, 32'h3, 6'd15);
        step(1'b1, 6'd3, 32'hF, 6'd3);
        step(1'b1, 6'd2, 32'h1, 6'd3);
        found = 0; cyc = 0;
        for (int i = 0; i < 40 && found < 3; i++) begin
            step(1'b0, 6'd0, 32'h0, 6'd3);
            cyc++;
            if (read_data_o[1]) begin
                check($sformatf("periodic event%0d timer", found), 64'(cyc - 1), 64'(exp_ev[found]));
                step(1'b1, 6'd3, 32'h2, 6'd12);
                cyc++;
                check($sformatf("periodic event%0d COMPARE_LO1", found), read_data_o, 32'(exp_cmp[found]));
                found++;
            end
        end
        check("periodic events seen", 64'(found), 64'd3);

        // Wrap from all-ones to zero with ch2 compare at 0x1_0000_0000
        step(1'b1, 6'd2, 32'h0, 6'd0);
        step(1'b1, 6'd16, 32'h0, 6'd16);
        step(1'b1, 6'd17, 32'h1, 6'd17);
        step(1'b1, 6'd19, 32'h1, 6'd19);
        step(1'b1, 6'd0, 32'hFFFF_FFFF, 6'd0);
        step(1'b1, 6'd1, 32'hFFFF_FFFF, 6'd1);
        step(1'b0, 6'd0, 32'h0, 6'd3);
        step(1'b1, 6'd3, 32'hF, 6'd3);
        step(1'b1, 6'd2, 32'h1, 6'd0);
        check("timer lo before wrap", read_data_o, 32'hFFFF_FFFF);
        step(1'b0, 6'd0, 32'h0, 6'd0);
        check("wrap TIMER_LO", read_data_o, 32'h0);
        step(1'b0, 6'd0, 32'h0, 6'd1);
        check("wrap TIMER_HI", read_data_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'd0, 32'h0, 6'd3);
            check("no spurious ch2 event after wrap", read_data_o[2], 1'b0);
        end

        // W1C of bit0 on the very edge that sets pending[0]
        step(1'b1, 6'd2, 32'h0, 6'd0);
        step(1'b1, 6'd0, 32'h0, 6'd0);
        step(1'b1, 6'd1, 32'h0, 6'd1);
        step(1'b1, 6'd8, 32'd3, 6'd8);
        step(1'b1, 6'd9, 32'h0, 6'd9);
        step(1'b1, 6'd11, 32'h1, 6'd11);
        step(1'b1, 6'd3, 32'hF, 6'd3);
        step(1'b1, 6'd2, 32'h1, 6'd0);
        repeat (3) step(1'b0, 6'd0, 32'h0, 6'd0);
        step(1'b1, 6'd3, 32'h1, 6'd3);
        check("event beats W1C pending0", read_data_o[0], 1'b1);
        check("event beats W1C irq0", channel_irq_o[0], 1'b1);
        step(1'b1, 6'd3, 32'h1, 6'd3);
        check("W1C clears pending0", read_data_o[0], 1'b0);

`ifdef MTIMER_PRESCALER_EN
        step(1'b1, 6'd2, 32'h0, 6'd0);
        step(1'b1, 6'd0, 32'h0, 6'd0);
        step(1'b1, 6'd4, 32'd3, 6'd4);
        check("PRESCALER readback", read_data_o, 32'd3);
        step(1'b1, 6'd2, 32'h1, 6'd0);
        for (int j = 1; j <= 12; j++) begin
            step(1'b0, 6'd0, 32'h0, 6'd0);
            check($sformatf("prescaled timer j%0d", j), read_data_o, 32'(j / 4));
        end
        step(1'b1, 6'd4, 32'h0, 6'd4);
`else
        step(1'b1, 6'd4, 32'd3, 6'd4);
        check("addr4 reads 0", read_data_o, 32'h0);
        step(1'b1, 6'd2, 32'h0, 6'd0);
        step(1'b1, 6'd0, 32'h0, 6'd0);
        step(1'b1, 6'd2, 32'h1, 6'd0);
        for (int j = 1; j <= 4; j++) begin
            step(1'b0, 6'd0, 32'h0, 6'd0);
            check($sformatf("unprescaled timer j%0d", j), read_data_o, 32'(j));
        end
`endif

        // Reset asserted with pending = 0101
        step(1'b1, 6'd2, 32'h0, 6'd0);
        step(1'b1, 6'd0, 32'h0, 6'd0);
        step(1'b1, 6'd8, 32'd2, 6'd8);
        step(1'b1, 6'd16, 32'd2, 6'd16);
        step(1'b1, 6'd17, 32'h0, 6'd17);
        step(1'b1, 6'd15, 32'h0, 6'd15);
        step(1'b1, 6'd3, 32'hF, 6'd3);
        step(1'b1, 6'd2, 32'h1, 6'd0);
        repeat (4) step(1'b0, 6'd0, 32'h0, 6'd0);
        step(1'b0, 6'd0, 32'h0, 6'd3);
        check("pending before reset", read_data_o, 32'h5);
        check("irq before reset", channel_irq_o, 4'h5);
        #3 rst_n_i = 1'b0;
        #1;
        check("reset mid-op channel_irq", channel_irq_o, 4'h0);
        check("reset mid-op timer_interrupt", timer_interrupt_o, 1'b0);
        check("reset mid-op STATUS", read_data_o, 32'h0);
        model_reset();
        #2;
        @(posedge clk_i);
        @(negedge clk_i) rst_n_i = 1'b1;
        read_address_i = 6'd0;
        #1 check("timer after reset release", read_data_o, 32'h0);
        step(1'b0, 6'd0, 32'h0, 6'd0);
        check("timer restarts", read_data_o, 32'h1);
        check("no irq after release", timer_interrupt_o, 1'b0);

        for (int i = 0; i < 1500; i++) rand_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
